// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared types and sizing helpers for the multi-cycle adder/subtractor.
package seq_addsub_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Narrowest legal chunk index register
  localparam int unsigned IDX_W_MIN = 1;

  // Number of chunks needed to cover the operand width
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Index register width: clog2 of the chunk count, never below one bit
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = (n <= 2) ? IDX_W_MIN : $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/seq_addsub_adder_chunk.sv
// full_adder / adder_chunk: ripple adder slice used by seq_addsub for one chunk per cycle.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  // Single-bit sum and carry
  always_comb begin
    s_o  = a_i ^ b_i ^ c_i;
    co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
  end

endmodule

module adder_chunk
  import seq_addsub_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  // c[k] is the carry into bit k; c[CHUNK] is the slice carry-out
  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  // Ripple chain of full adders
  for (genvar k = 0; k < CHUNK; k++) begin : g_fa
    full_adder u_fa (
      .a_i  (a_i[k]),
      .b_i  (b_i[k]),
      .c_i  (c[k]),
      .s_o  (sum_o[k]),
      .co_o (c[k+1])
    );
  end

  // Carry into the top bit is exposed so the caller can form signed overflow
  assign cout_o  = c[CHUNK];
  assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor, CHUNK bits per BUSY cycle, valid/ready on both sides.
// Build option: define SEQ_ADDSUB_FAST_EN to complete the whole WIDTH-bit add in one BUSY cycle.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

`ifdef SEQ_ADDSUB_FAST_EN
  localparam int unsigned CW = WIDTH;
`else
  localparam int unsigned CW = CHUNK;
`endif
  localparam int unsigned NCH = nchunk(WIDTH, CW);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, ovf_q, zero_q;

  logic             accept_c;
  logic             last_c;
  logic [CW-1:0]    op_a_c, op_b_c, res_c;
  logic             cout_c, cmsb_c;
  logic [WIDTH-1:0] sum_next_c;

`ifdef SEQ_ADDSUB_FAST_EN
  // Whole word is one slice; every BUSY cycle is the last
  assign op_a_c     = a_q;
  assign op_b_c     = b_q;
  assign last_c     = 1'b1;
  assign sum_next_c = res_c;
`else
  localparam int unsigned      IDX_W     = idx_width(NCH);
  localparam logic [WIDTH-1:0] LANE_MASK = WIDTH'({CW{1'b1}});

  logic [IDX_W-1:0] idx_q;
  logic [31:0]      off_c;

  // Bit offset of the current chunk
  assign off_c  = 32'(idx_q) * 32'(CW);
  assign op_a_c = CW'(a_q >> off_c);
  assign op_b_c = CW'(b_q >> off_c);
  assign last_c = (idx_q == IDX_W'(NCH - 1));

  // Merge the freshly computed chunk into the running result
  always_comb begin
    sum_next_c = (sum_q & ~(LANE_MASK << off_c)) | (WIDTH'(res_c) << off_c);
  end
`endif

  adder_chunk #(
    .CHUNK (CW)
  ) u_adder (
    .a_i     (op_a_c),
    .b_i     (op_b_c),
    .cin_i   (c_q),
    .sum_o   (res_c),
    .cout_o  (cout_c),
    .c_msb_o (cmsb_c)
  );

  assign accept_c = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_BUSY;
      ST_BUSY: if (last_c) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready held low during reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = ~rst;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, per-chunk accumulation and flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifndef SEQ_ADDSUB_FAST_EN
      idx_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            c_q   <= sub ? 1'b1 : cin;
`ifndef SEQ_ADDSUB_FAST_EN
            idx_q <= '0;
`endif
          end
        end
        ST_BUSY: begin
          sum_q <= sum_next_c;
          c_q   <= cout_c;
`ifndef SEQ_ADDSUB_FAST_EN
          idx_q <= last_c ? '0 : idx_q + IDX_W'(1);
`endif
          if (last_c) begin
            carry_q <= cout_c;
            ovf_q   <= cout_c ^ cmsb_c;
            zero_q  <= (sum_next_c == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: directed and random checks of seq_addsub against an arithmetic reference.
module tb_seq_addsub #(
  parameter int unsigned TB_CHUNK = 4
);

  localparam int unsigned W = 16;
`ifdef SEQ_ADDSUB_FAST_EN
  localparam int unsigned EXP_LAT = 1;
`else
  localparam int unsigned EXP_LAT = W / TB_CHUNK;
`endif

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, sum;
  logic          in_cin, in_sub, carry, overflow, zero;

  int n_assert = 0;
  int n_fail   = 0;

  seq_addsub #(
    .WIDTH (W),
    .CHUNK (TB_CHUNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (in_a),
    .b         (in_b),
    .cin       (in_cin),
    .sub       (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sb, output logic [W-1:0] s, output logic c,
                       output logic o, output logic z);
    int sa, sbv, r, u;
    sa  = $signed(a);
    sbv = $signed(b);
    if (sb) begin
      s = a - b;
      c = (a >= b);
      r = sa - sbv;
    end else begin
      u = int'(a) + int'(b) + int'(ci);
      s = W'(u);
      c = (u > 65535);
      r = sa + sbv + int'(ci);
    end
    o = (r > 32767) || (r < -32768);
    z = (s == '0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Issue one operation, check latency, result, flags and handoff
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb);
    logic [W-1:0] es;
    logic ec, eo, ez;
    int lat;
    model(a, b, ci, sb, es, ec, eo, ez);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = ci; in_sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom); in_sub = 1'($urandom);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    wait_done(lat);
    chk("latency", 32'(lat), 32'(EXP_LAT));
    chk("sum", 32'(sum), 32'(es));
    chk("carry", 32'(carry), 32'(ec));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("zero", 32'(zero), 32'(ez));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] es;
    logic ec, eo, ez;
    int lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", {29'd0, carry, overflow, zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    run_op(16'h0003, 16'h0005, 1'b1, 1'b1);

    // Backpressure: result held while new requests are presented in DONE
    model(16'h1357, 16'h0ACE, 1'b1, 1'b0, es, ec, eo, ez);
    in_a = 16'h1357; in_b = 16'h0ACE; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp_latency", 32'(lat), 32'(EXP_LAT));
    in_valid = 1'b1; in_a = 16'hDEAD; in_b = 16'hBEEF; in_sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'(es));
      chk("bp_flags", {29'd0, carry, overflow, zero}, {29'd0, ec, eo, ez});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_no_accept", 32'(in_ready), 32'd1);

    // Reset during BUSY
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_flags", {29'd0, carry, overflow, zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_idle", 32'(in_ready), 32'd1);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
Parametrised, multi-cycle adder/subtractor for the datapath. Operand width and per-cycle chunk size are configurable. The block processes CHUNK bits per clock through a ripple chunk adder and carries between chunks in a register. Valid/ready handshakes on input and output let the ALU sequencer stall it; the block reports carry, signed overflow and zero flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per BUSY cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept an operation (IDLE only).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used in add mode only.
- sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1; cin ignored).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- carry  output  1  carry out of the MSB; in sub mode 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk; reset port is rst.
- NCHUNK = WIDTH/CHUNK. FSM states are IDLE, BUSY, DONE.
- Reset (any state, including mid-BUSY): state goes to IDLE, chunk index to 0. sum, carry, overflow, zero and out_valid go to 0; the internal operand/carry registers are cleared. in_ready is forced 0 while rst is high and is 1 in the first cycle after rst deasserts.
- IDLE: in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at a clock edge: latch a; latch b, or ~b if sub; latch the carry register with cin, or 1 if sub. Go to BUSY with index 0.
- BUSY: in_ready = 0.
  - Each edge adds chunk[index] of the latched operands plus the carry register.
  - The result is written into sum[index*CHUNK +: CHUNK] and the chunk carry-out is stored; index increments.
  - On the edge that processes chunk NCHUNK-1: capture carry, overflow (using the carry into bit WIDTH-1 from the chunk adder) and zero, then go to DONE.
- DONE: out_valid = 1, in_ready = 0.
  - sum and flags are held stable until out_ready = 1 at a clock edge, then the state goes to IDLE.
  - No accept in the same cycle as the handoff.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. Minimum issue interval is NCHUNK+2 cycles.
- in_valid outside IDLE is ignored. Input operand changes after acceptance have no effect.
- sum is partially updated during BUSY and is only meaningful while out_valid = 1.
- Width rules: all arithmetic is modulo 2^WIDTH; no sign extension.
- CHUNK = WIDTH is legal: one BUSY cycle.

Optional Feature:
- Macro SEQ_ADDSUB_FAST_EN.
  - Defined: the whole WIDTH-bit add completes in a single BUSY cycle regardless of CHUNK (latency 1; index logic removed). Handshake and flags are unchanged.
  - Undefined: chunked behaviour as above.

Decomposition:
- Package seq_addsub_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - function nchunk(WIDTH, CHUNK);
  - localparam for the index width, $clog2(NCHUNK) with a minimum of 1.
- One sub-module, adder_chunk: CHUNK-bit ripple adder built from full_adder cells. Outputs are sum, carry out, and carry into the top bit (for overflow).

Test Plan:
All cases use WIDTH=16, CHUNK=4 unless stated.
- Add 0x00FF+0x0001, cin=0 -> sum 0x0100, carry 0, overflow 0, zero 0; out_valid exactly 4 cycles after accept.
- Add 0xFFFF+0x0001, cin=0 -> sum 0x0000, carry 1, zero 1, overflow 0. Add 0x7FFF+0x0000, cin=1 -> 0x8000, overflow 1.
- Sub 0x8000-0x0001 -> 0x7FFF, carry 1, overflow 1. Sub 0x0003-0x0005 -> 0xFFFE, carry 0, overflow 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum and flags stable, in_ready 0, new operands not accepted. Then out_ready=1 -> IDLE next cycle, in_ready 1.
- Assert rst for 1 cycle after 2 BUSY chunks -> next cycle IDLE, out_valid 0, sum 0. Subsequent add 0x1234+0x1111 -> 0x2345 correct.
- Rerun the first three cases with CHUNK=16 and with SEQ_ADDSUB_FAST_EN defined -> same values, latency 1.
